// File: rtl/jtframe_romrq_arb_pkg.sv
// Shared types and helpers for the ROM request arbiter.
// FSM encoding, data width and slot index sizing.
package jtframe_romrq_arb_pkg;

  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jtframe_romrq_arb_if.sv
// SDRAM bank port bundle between the arbiter and the SDRAM controller.
// master drives the request, slave answers with ack/rdy/data.
interface jtframe_romrq_arb_if
  import jtframe_romrq_arb_pkg::*;
#(
  parameter int AW = 22
) ();

  logic [AW-1:0] ba_addr;
  logic          ba_rd;
  logic          ba_ack;
  logic          ba_rdy;
  logic [DW-1:0] sdram_dout;

  modport master (
    output ba_addr,
    output ba_rd,
    input  ba_ack,
    input  ba_rdy,
    input  sdram_dout
  );

  modport slave (
    input  ba_addr,
    input  ba_rd,
    output ba_ack,
    output ba_rdy,
    output sdram_dout
  );

endinterface

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin picker.
// Returns the first requester after i_last, wrapping around.
module jtframe_rr_pick
  import jtframe_romrq_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  localparam int IW = idx_w(SLOTS)
) (
  input  logic [SLOTS-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [IW-1:0]    o_gnt,
  output logic             o_any
);

  // Walk downwards so the closest slot after i_last wins
  always_comb begin
    o_gnt = i_last;
    o_any = 1'b0;
    for (int k = SLOTS; k >= 1; k--) begin
      logic [IW-1:0] w_idx;
      w_idx = IW'((int'(i_last) + k) % SLOTS);
      if (i_req[w_idx]) begin
        o_gnt = w_idx;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtframe_romrq_arb.sv
// N-slot ROM read arbiter onto one SDRAM bank port.
// One-entry cache per slot, round-robin among missing slots.
module jtframe_romrq_arb
  import jtframe_romrq_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               invalidate,
  input  logic [SLOTS-1:0]   slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]   slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic               busy,
  jtframe_romrq_arb_if.master ba
);

  localparam int IW = idx_w(SLOTS);

  state_t         r_st;
  logic [IW-1:0]  r_gnt;
  logic [IW-1:0]  r_rr;
  logic [AW-1:0]  r_addr;
  logic           r_rd;
  logic           r_drop;
  logic [AW-1:0]  r_tag  [SLOTS];
  logic [DW-1:0]  r_data [SLOTS];
  logic [SLOTS-1:0] r_valid;

  logic [SLOTS-1:0] w_hit;
  logic [SLOTS-1:0] w_pend;
  logic [IW-1:0]    w_gnt;
  logic             w_any;
  logic             w_done;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign w_hit[i] = r_valid[i] &&
      (r_tag[i] == slot_addr[i*AW +: AW]);
    assign slot_dout[i*DW +: DW] = r_data[i];
  end

  assign slot_ok = slot_cs & w_hit;
  assign w_pend  = slot_cs & ~w_hit;
  assign busy    = (r_st != IDLE);

  assign ba.ba_addr = r_addr;
  assign ba.ba_rd   = r_rd;

  jtframe_rr_pick #(
    .SLOTS (SLOTS)
  ) u_pick (
    .i_req  (w_pend),
    .i_last (r_rr),
    .o_gnt  (w_gnt),
    .o_any  (w_any)
  );

  // ack and rdy in the same cycle short-cuts REQ straight to completion
  assign w_done =
    (r_st == REQ  && ba.ba_ack && ba.ba_rdy) ||
    (r_st == WAIT && ba.ba_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st    <= IDLE;
      r_gnt   <= '0;
      r_rr    <= IW'(SLOTS - 1);
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_drop  <= 1'b0;
      r_valid <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (invalidate) r_valid <= '0;
      unique case (r_st)
        IDLE: begin
          if (w_any) begin
            r_gnt  <= w_gnt;
            r_rr   <= w_gnt;
            r_addr <= slot_addr[w_gnt*AW +: AW];
            r_rd   <= 1'b1;
            r_drop <= 1'b0;
            r_st   <= REQ;
          end
        end
        REQ: begin
          if (invalidate) r_drop <= 1'b1;
          if (ba.ba_ack) begin
            r_rd <= 1'b0;
            r_st <= WAIT;
          end
        end
        WAIT: begin
          if (invalidate) r_drop <= 1'b1;
        end
        default: r_st <= IDLE;
      endcase
      if (w_done) begin
        r_data[r_gnt]  <= ba.sdram_dout;
        r_tag[r_gnt]   <= r_addr;
        r_valid[r_gnt] <= ~(r_drop | invalidate);
        r_st           <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_romrq_arb.sv
// Directed bench for jtframe_romrq_arb with an SDRAM responder.
// Expected grants are queued as stimulus is driven.
module tb_jtframe_romrq_arb;
  import jtframe_romrq_arb_pkg::*;

  localparam int S  = 4;
  localparam int AW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             invalidate;
  logic [S-1:0]     cs;
  logic [S*AW-1:0]  addr;
  logic [S-1:0]     ok;
  logic [S*DW-1:0]  dout;
  logic             busy;

  jtframe_romrq_arb_if #(.AW(AW)) bus ();

  jtframe_romrq_arb #(
    .SLOTS (S),
    .AW    (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .invalidate (invalidate),
    .slot_cs    (cs),
    .slot_addr  (addr),
    .slot_ok    (ok),
    .slot_dout  (dout),
    .busy       (busy),
    .ba         (bus)
  );

  typedef struct {
    int            slot;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int s, input logic [AW-1:0] a);
    addr[s*AW +: AW] = a;
  endtask

  task automatic push(input int s, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    exp_t e;
    e.slot = s;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_rd();
    for (int i = 0; i < 20 && bus.ba_rd !== 1'b1; i++) tick();
    chk("rd_wait", 32'(bus.ba_rd), 32'd1);
    if (sb.size() > 0) begin
      cur = sb.pop_front();
    end else begin
      total++;
      bad++;
      $error("FAIL sb_pop: got empty queue want entry");
    end
    chk("ba_addr", 32'(bus.ba_addr), 32'(cur.addr));
  endtask

  task automatic ack_pulse(input bit with_rdy,
                           input logic [DW-1:0] d);
    bus.ba_ack = 1'b1;
    if (with_rdy) begin
      bus.ba_rdy     = 1'b1;
      bus.sdram_dout = d;
    end
    tick();
    bus.ba_ack = 1'b0;
    bus.ba_rdy = 1'b0;
  endtask

  task automatic rdy_pulse(input logic [DW-1:0] d);
    bus.ba_rdy     = 1'b1;
    bus.sdram_dout = d;
    tick();
    bus.ba_rdy = 1'b0;
  endtask

  task automatic serve(input int ack_d, input int rdy_d);
    repeat (ack_d - 1) tick();
    if (rdy_d == 0) begin
      ack_pulse(1'b1, cur.data);
    end else begin
      ack_pulse(1'b0, '0);
      chk("rd_drop", 32'(bus.ba_rd), 32'd0);
      repeat (rdy_d - 1) tick();
      rdy_pulse(cur.data);
    end
    chk("dout", 32'(dout[cur.slot*DW +: DW]), 32'(cur.data));
    chk("idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    invalidate     = 1'b0;
    cs             = '0;
    addr           = '0;
    bus.ba_ack     = 1'b0;
    bus.ba_rdy     = 1'b0;
    bus.sdram_dout = '0;
    tick();
    tick();
    chk("rst_rd", 32'(bus.ba_rd), 32'd0);
    chk("rst_addr", 32'(bus.ba_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dout", 32'(dout == '0), 32'd1);
    rst_n = 1'b1;
    tick();

    // reset while a request is outstanding
    cs[1] = 1'b1;
    set_addr(1, 22'h77);
    tick();
    chk("req_rd", 32'(bus.ba_rd), 32'd1);
    chk("req_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd", 32'(bus.ba_rd), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ok", 32'(ok), 32'd0);
    cs = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // single miss, then hit without SDRAM traffic
    set_addr(0, 22'h1234);
    cs[0] = 1'b1;
    push(0, 22'h1234, 16'hBEEF);
    tick();
    chk("rd_lat", 32'(bus.ba_rd), 32'd1);
    wait_rd();
    serve(1, 2);
    chk("ok0", 32'(ok[0]), 32'd1);
    cs[0] = 1'b0;
    tick();
    cs[0] = 1'b1;
    #1;
    chk("hit0", 32'(ok[0]), 32'd1);
    tick();
    chk("hit0_nord", 32'(bus.ba_rd), 32'd0);
    chk("hit0_idle", 32'(busy), 32'd0);
    cs = '0;

    // all four miss; slot0 re-misses while slot1 is served
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < S; i++) set_addr(i, AW'(22'h100 + i));
    cs = 4'hF;
    push(0, 22'h100, 16'hA000);
    push(1, 22'h101, 16'hA001);
    wait_rd();
    serve(1, 1);
    wait_rd();
    set_addr(0, 22'h200);
    push(2, 22'h102, 16'hA002);
    push(3, 22'h103, 16'hA003);
    push(0, 22'h200, 16'hB000);
    serve(1, 1);
    for (int k = 0; k < 3; k++) begin
      wait_rd();
      serve(2, 1);
    end
    chk("all_ok", 32'(ok), 32'hF);

    // slot2 moves its address after ack
    cs = 4'b0100;
    set_addr(2, 22'h10);
    push(2, 22'h10, 16'hC000);
    wait_rd();
    ack_pulse(1'b0, '0);
    set_addr(2, 22'h20);
    tick();
    rdy_pulse(cur.data);
    chk("mv_dout", 32'(dout[2*DW +: DW]), 32'hC000);
    chk("mv_ok", 32'(ok[2]), 32'd0);
    push(2, 22'h20, 16'hC001);
    wait_rd();
    set_addr(2, 22'h10);
    #1;
    chk("mv_tag", 32'(ok[2]), 32'd1);
    set_addr(2, 22'h20);
    #1;
    serve(1, 1);
    chk("mv_ok2", 32'(ok[2]), 32'd1);

    // invalidate between ack and rdy
    cs = 4'b1000;
    set_addr(3, 22'h300);
    push(3, 22'h300, 16'hD000);
    wait_rd();
    ack_pulse(1'b0, '0);
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    rdy_pulse(cur.data);
    chk("inv_dout", 32'(dout[3*DW +: DW]), 32'hD000);
    chk("inv_ok", 32'(ok[3]), 32'd0);
    push(3, 22'h300, 16'hD001);
    tick();
    chk("inv_rereq", 32'(bus.ba_rd), 32'd1);
    wait_rd();
    serve(1, 1);
    chk("inv_ok2", 32'(ok[3]), 32'd1);
    cs[2] = 1'b1;
    #1;
    chk("inv_clr2", 32'(ok[2]), 32'd0);
    push(2, 22'h20, 16'hE000);
    wait_rd();
    serve(1, 1);
    chk("inv_ok_all", 32'(ok), 32'hC);

    // ack and rdy in one cycle
    cs = 4'b0010;
    set_addr(1, 22'h55);
    push(1, 22'h55, 16'h5A5A);
    wait_rd();
    serve(1, 0);
    chk("fast_ok", 32'(ok[1]), 32'd1);
    chk("fast_rd", 32'(bus.ba_rd), 32'd0);
    tick();
    chk("fast_norq", 32'(bus.ba_rd), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
